// File: rtl/core_pkg.sv
// Shared core definitions: architectural register file geometry and the
// flag bundle reported by each per-register pending-write counter.
package core_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = $clog2(NREG);

    typedef logic [REG_AW-1:0] reg_idx_t;

    typedef struct packed {
        logic zero;
        logic max;
    } cnt_flags_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Bundle between decode/write-back and the scoreboarded register file.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2
);
    localparam int AW = $clog2(NREG);

    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rbusy;
    logic                we3;
    logic [AW-1:0]       wa3;
    logic [XLEN-1:0]     wd3;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                iss_ready;
    logic                flush;
    logic                sb_err;

    // Issue handshake: an issue is taken at a rising edge only when
    // iss_valid && iss_ready; iss_ready never depends on iss_valid, and
    // iss_valid may be withdrawn at any time without side effects.
    modport master (
        output ra, we3, wa3, wd3, iss_valid, iss_rd, flush,
        input  rd, rbusy, iss_ready, sb_err
    );

    modport slave (
        input  ra, we3, wa3, wd3, iss_valid, iss_rd, flush,
        output rd, rbusy, iss_ready, sb_err
    );

endinterface

// File: rtl/sb_counter.sv
// Saturating-by-contract up/down pending-write counter for one register.
module sb_counter
    import core_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output cnt_flags_t   flags
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         dec_eff;

    always_comb begin
        // A decrement on an empty counter is an underflow; it is ignored here.
        dec_eff = dec && (cnt_q != '0);
        cnt_d   = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec_eff && (cnt_q != '1)) begin
            cnt_d = cnt_q + ONE;
        end else if (dec_eff && !inc) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt        = cnt_q;
    assign flags.zero = (cnt_q == '0);
    assign flags.max  = (cnt_q == '1);

endmodule

// File: rtl/regfile_sb.sv
// Register file with combinational read ports, write-back bypass, hardwired
// zero register and a per-register pending-write scoreboard for RAW stalls.
module regfile_sb
    import core_pkg::*;
#(
    parameter int XLEN     = core_pkg::XLEN,
    parameter int NREG     = core_pkg::NREG,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int PCNT_W   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);
    localparam int AW = $clog2(NREG);
    localparam logic [PCNT_W-1:0] CNT_ONE = PCNT_W'(1);

    logic [XLEN-1:0]   rf_q [NREG];
    logic [XLEN-1:0]   rf_d [NREG];
    logic [PCNT_W-1:0] cnt  [NREG];
    cnt_flags_t        flags[NREG];
    logic              sb_err_q;
    logic              sb_err_d;
    logic              inc_en;
    logic              iss_ready;
    logic [NRD*XLEN-1:0] rd_v;
    logic [NRD-1:0]      rbusy_v;

    always_comb begin
        rf_d = rf_q;
        if (bus.we3 && !(ZERO_REG != 0 && bus.wa3 == '0)) rf_d[bus.wa3] = bus.wd3;
    end

    // Async clear is why the array stays in flops rather than a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rf_q <= '{default: '0};
        else        rf_q <= rf_d;
    end

    // A write-back in the same cycle frees a slot on a saturated destination.
    assign iss_ready = !flags[bus.iss_rd].max || (bus.we3 && bus.wa3 == bus.iss_rd);
    assign inc_en    = bus.iss_valid && iss_ready && !(ZERO_REG != 0 && bus.iss_rd == '0);

    for (genvar r = 0; r < NREG; r++) begin : g_cnt
        if (ZERO_REG != 0 && r == 0) begin : g_tie
            assign cnt[r]        = '0;
            assign flags[r].zero = 1'b1;
            assign flags[r].max  = 1'b0;
        end else begin : g_inst
            sb_counter #(.W(PCNT_W)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (inc_en && bus.iss_rd == AW'(r)),
                .dec   (bus.we3 && bus.wa3 == AW'(r)),
                .clr   (bus.flush),
                .cnt   (cnt[r]),
                .flags (flags[r])
            );
        end
    end

    always_comb begin
        sb_err_d = sb_err_q;
        if (bus.we3 && flags[bus.wa3].zero && !bus.flush) sb_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sb_err_q <= 1'b0;
        else        sb_err_q <= sb_err_d;
    end

    always_comb begin
        rd_v    = '0;
        rbusy_v = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0] a;
            logic          zero_hit;
            logic          byp_hit;
            a        = bus.ra[i*AW +: AW];
            zero_hit = (ZERO_REG != 0) && (a == '0);
            byp_hit  = (BYPASS != 0) && bus.we3 && (bus.wa3 == a);
            if (zero_hit)     rd_v[i*XLEN +: XLEN] = '0;
            else if (byp_hit) rd_v[i*XLEN +: XLEN] = bus.wd3;
            else              rd_v[i*XLEN +: XLEN] = rf_q[a];
            // The last outstanding write landing this cycle satisfies the read.
            rbusy_v[i] = !zero_hit && !flags[a].zero && !(byp_hit && cnt[a] == CNT_ONE);
        end
    end

    assign bus.rd        = rd_v;
    assign bus.rbusy     = rbusy_v;
    assign bus.iss_ready = iss_ready;
    assign bus.sb_err    = sb_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a bypassing and a non-bypassing instance
// see identical stimulus; a negedge monitor drains an expected-value queue.
module tb_regfile_sb;
    import core_pkg::*;

    localparam int K_RD0    = 0;
    localparam int K_RD1    = 1;
    localparam int K_BUSY0  = 2;
    localparam int K_BUSY1  = 3;
    localparam int K_READY  = 4;
    localparam int K_ERR    = 5;
    localparam int K_RD0_NB = 6;

    logic clk;
    logic rst_n;
    logic chk_stb;

    int n_total;
    int n_bad;

    int          kind_q[$];
    logic [31:0] exp_q[$];
    string       name_q[$];

    regfile_sb_if #(.XLEN(32), .NREG(32), .NRD(2)) bus ();
    regfile_sb_if #(.XLEN(32), .NREG(32), .NRD(2)) bus_nb ();

    assign bus_nb.ra        = bus.ra;
    assign bus_nb.we3       = bus.we3;
    assign bus_nb.wa3       = bus.wa3;
    assign bus_nb.wd3       = bus.wd3;
    assign bus_nb.iss_valid = bus.iss_valid;
    assign bus_nb.iss_rd    = bus.iss_rd;
    assign bus_nb.flush     = bus.flush;

    regfile_sb #(.NRD(2), .BYPASS(1), .ZERO_REG(1), .PCNT_W(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    regfile_sb #(.NRD(2), .BYPASS(0), .ZERO_REG(1), .PCNT_W(2)) u_dut_nb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nb)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic rd_addr(input logic [4:0] a0, input logic [4:0] a1);
        bus.ra = {a1, a0};
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bus.we3 = 1'b1;
        bus.wa3 = a;
        bus.wd3 = d;
    endtask

    task automatic issue(input logic [4:0] r);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = r;
    endtask

    task automatic expect_val(input int k, input logic [31:0] v, input string n);
        kind_q.push_back(k);
        exp_q.push_back(v);
        name_q.push_back(n);
    endtask

    task automatic step();
        chk_stb = 1'b1;
        @(posedge clk);
        #1;
        chk_stb       = 1'b0;
        bus.we3       = 1'b0;
        bus.iss_valid = 1'b0;
        bus.flush     = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    function automatic logic [31:0] observe(input int k);
        case (k)
            K_RD0:    return bus.rd[31:0];
            K_RD1:    return bus.rd[63:32];
            K_BUSY0:  return {31'd0, bus.rbusy[0]};
            K_BUSY1:  return {31'd0, bus.rbusy[1]};
            K_READY:  return {31'd0, bus.iss_ready};
            K_ERR:    return {31'd0, bus.sb_err};
            K_RD0_NB: return bus_nb.rd[31:0];
            default:  return 32'hxxxx_xxxx;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_stb) begin
            while (exp_q.size() > 0) begin
                int          k;
                logic [31:0] e;
                logic [31:0] got;
                string       n;
                k   = kind_q.pop_front();
                e   = exp_q.pop_front();
                n   = name_q.pop_front();
                got = observe(k);
                n_total++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL %s: got=%h want=%h", n, got, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_total       = 0;
        n_bad         = 0;
        chk_stb       = 1'b0;
        rst_n         = 1'b0;
        bus.ra        = '0;
        bus.we3       = 1'b0;
        bus.wa3       = '0;
        bus.wd3       = '0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = '0;
        bus.flush     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state: every register reads 0 and is not busy.
        expect_val(K_READY, 32'd1, "reset_ready");
        expect_val(K_ERR, 32'd0, "reset_sb_err");
        for (int i = 0; i < 16; i++) begin
            rd_addr(5'(2 * i), 5'(2 * i + 1));
            expect_val(K_RD0, 32'd0, "reset_rd0");
            expect_val(K_RD1, 32'd0, "reset_rd1");
            expect_val(K_BUSY0, 32'd0, "reset_busy0");
            expect_val(K_BUSY1, 32'd0, "reset_busy1");
            step();
        end

        // x5: issued then written, visible the following cycle.
        issue(5'd5);
        expect_val(K_READY, 32'd1, "x5_issue_ready");
        step();
        wb(5'd5, 32'hDEAD_BEEF);
        step();
        rd_addr(5'd5, 5'd0);
        expect_val(K_RD0, 32'hDEAD_BEEF, "x5_read");
        expect_val(K_RD0_NB, 32'hDEAD_BEEF, "x5_read_nb");
        expect_val(K_ERR, 32'd0, "x5_no_err");
        step();

        // x7: same-cycle bypass vs. array-only read.
        issue(5'd7);
        step();
        wb(5'd7, 32'hA5A5_A5A5);
        rd_addr(5'd7, 5'd0);
        expect_val(K_RD0, 32'hA5A5_A5A5, "x7_bypass");
        expect_val(K_RD0_NB, 32'h0000_0000, "x7_nobypass_old");
        expect_val(K_BUSY0, 32'd0, "x7_busy_bypassed");
        step();
        expect_val(K_RD0_NB, 32'hA5A5_A5A5, "x7_nobypass_next");
        step();

        // x3: two pending writes, retired one at a time.
        issue(5'd3);
        expect_val(K_READY, 32'd1, "x3_issue1_ready");
        step();
        issue(5'd3);
        rd_addr(5'd0, 5'd3);
        expect_val(K_BUSY1, 32'd1, "x3_busy_cnt1");
        step();
        wb(5'd3, 32'h0000_0033);
        rd_addr(5'd3, 5'd0);
        expect_val(K_BUSY0, 32'd1, "x3_busy_wb1_same");
        step();
        expect_val(K_BUSY0, 32'd1, "x3_busy_after_wb1");
        step();
        wb(5'd3, 32'h0000_0044);
        expect_val(K_BUSY0, 32'd0, "x3_busy_wb2_same");
        expect_val(K_RD0, 32'h0000_0044, "x3_rd_wb2_bypass");
        step();
        expect_val(K_BUSY0, 32'd0, "x3_busy_after_wb2");
        expect_val(K_RD0, 32'h0000_0044, "x3_rd_after_wb2");
        step();

        // x4: saturate the 2-bit counter, then issue+write-back together.
        for (int i = 0; i < 3; i++) begin
            issue(5'd4);
            expect_val(K_READY, 32'd1, "x4_fill_ready");
            step();
        end
        bus.iss_rd = 5'd4;
        rd_addr(5'd4, 5'd0);
        expect_val(K_READY, 32'd0, "x4_saturated");
        expect_val(K_BUSY0, 32'd1, "x4_busy");
        step();
        issue(5'd4);
        wb(5'd4, 32'h0000_0004);
        expect_val(K_READY, 32'd1, "x4_ready_with_wb");
        expect_val(K_BUSY0, 32'd1, "x4_busy_cnt3_wb");
        step();
        bus.iss_rd = 5'd4;
        expect_val(K_READY, 32'd0, "x4_still_saturated");
        step();

        // Flush with x4, x8, x9 pending; then an unexpected write-back to x8.
        issue(5'd8);
        step();
        issue(5'd9);
        step();
        bus.flush = 1'b1;
        rd_addr(5'd4, 5'd8);
        expect_val(K_BUSY0, 32'd1, "flush_x4_busy_before");
        expect_val(K_BUSY1, 32'd1, "flush_x8_busy_before");
        step();
        bus.iss_rd = 5'd4;
        expect_val(K_BUSY0, 32'd0, "flush_x4_clear");
        expect_val(K_BUSY1, 32'd0, "flush_x8_clear");
        expect_val(K_READY, 32'd1, "flush_x4_ready");
        expect_val(K_ERR, 32'd0, "flush_no_err");
        step();
        rd_addr(5'd9, 5'd8);
        wb(5'd8, 32'h1111_2222);
        expect_val(K_BUSY0, 32'd0, "flush_x9_clear");
        expect_val(K_RD1, 32'h1111_2222, "x8_wb_bypass");
        expect_val(K_ERR, 32'd0, "sb_err_not_yet");
        step();
        expect_val(K_RD1, 32'h1111_2222, "x8_written");
        expect_val(K_ERR, 32'd1, "sb_err_set");
        step();

        // Zero register ignores writes, including the bypass path.
        wb(5'd0, 32'h0000_1234);
        rd_addr(5'd0, 5'd5);
        expect_val(K_RD0, 32'd0, "x0_bypass_zero");
        expect_val(K_BUSY0, 32'd0, "x0_never_busy");
        step();
        expect_val(K_RD0, 32'd0, "x0_still_zero");
        expect_val(K_RD1, 32'hDEAD_BEEF, "x5_retained");
        expect_val(K_ERR, 32'd1, "sb_err_sticky");
        step();

        // Asynchronous reset in the middle of activity.
        issue(5'd10);
        step();
        wb(5'd11, 32'hCAFE_0011);
        step();
        rd_addr(5'd11, 5'd10);
        expect_val(K_RD0, 32'hCAFE_0011, "pre_rst_x11");
        expect_val(K_BUSY1, 32'd1, "pre_rst_x10_busy");
        step();
        rst_n      = 1'b0;
        bus.iss_rd = 5'd10;
        expect_val(K_RD0, 32'd0, "rst_async_rd0");
        expect_val(K_RD0_NB, 32'd0, "rst_async_rd0_nb");
        expect_val(K_BUSY1, 32'd0, "rst_async_busy1");
        expect_val(K_READY, 32'd1, "rst_async_ready");
        expect_val(K_ERR, 32'd0, "rst_async_sb_err");
        step();
        rst_n = 1'b1;
        expect_val(K_RD0, 32'd0, "post_rst_rd0");
        expect_val(K_BUSY1, 32'd0, "post_rst_busy1");
        step();

        if (exp_q.size() != 0) begin
            n_total++;
            n_bad++;
            $display("FAIL queue_drain: got=%0d want=0 entries left", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
